// File: rtl/s420_pkg.sv
// s420_pkg: shared constants and state type for the s420 deserializer and its bench model.
package s420_pkg;
    localparam int SLOT_COUNT = 17;
    localparam int FRAME_BITS = SLOT_COUNT;
    localparam int IDX_W = 5;
    typedef enum logic {IDLE, COLLECT} state_t;
endpackage

// File: rtl/s420_deser_if.sv
// s420_deser_if: serial-in / parallel-out bus between link, deserializer and word consumer.
interface s420_deser_if;
    import s420_pkg::*;
    logic P_0, SYNC, D, ACK;
    logic [FRAME_BITS-1:0] C;
    logic VALID, OVR, SYNCERR;
    logic [IDX_W-1:0] IDX;
    modport master (output P_0, SYNC, D, ACK, input C, VALID, OVR, SYNCERR, IDX);
    modport slave (input P_0, SYNC, D, ACK, output C, VALID, OVR, SYNCERR, IDX);
endinterface

// File: rtl/s420_slot_ctr.sv
// s420_slot_ctr: mod-FRAME_BITS slot counter built from cascaded nibble stages with carry enable.
module s420_slot_ctr import s420_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    output logic [IDX_W-1:0] idx,
    output logic             wrap
);
    localparam int NIB = (IDX_W + 3) / 4;
    logic [NIB-1:0] cy;
    assign cy[0] = en;
    assign wrap = en && idx == IDX_W'(FRAME_BITS - 1);
    for (genvar n = 0; n < NIB; n++) begin : g_nib
        localparam int W = (n == NIB - 1) ? IDX_W - 4 * n : 4;
        logic [W-1:0] q;
        assign idx[4*n +: W] = q;
        if (n < NIB - 1) begin : g_cy
            assign cy[n+1] = cy[n] & (&q);
        end
        // Resync loads 1 because slot 0 is written by the SYNC bit itself
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) q <= '0;
            else if (load) q <= (n == 0) ? W'(1) : '0;
            else if (wrap) q <= '0;
            else if (cy[n]) q <= q + W'(1);
    end
endmodule

// File: rtl/s420_deser.sv
// s420_deser: slot-indexed serial bits in, registered FRAME_BITS-wide word out with valid/ack.
module s420_deser import s420_pkg::*; (
    input logic         CK,
    input logic         RN,
    s420_deser_if.slave bus
);
    state_t state, state_nxt;
    logic [FRAME_BITS-1:0] buf_q, buf_nxt;
    logic ld, en, wrap, serr;
    s420_slot_ctr u_ctr (.clk(CK), .rst_n(RN), .en(en), .load(ld), .idx(bus.IDX), .wrap(wrap));
    always_ff @(posedge CK or negedge RN)
        if (!RN) state <= IDLE;
        else state <= state_nxt;
    always_comb state_nxt = (bus.P_0 && bus.SYNC) ? COLLECT : state;
    always_comb begin
        ld = bus.P_0 && bus.SYNC;
        en = bus.P_0 && !bus.SYNC && state == COLLECT;
        serr = ld && state == COLLECT && bus.IDX != '0;
        buf_nxt = buf_q;
        buf_nxt[bus.IDX] = bus.D;
        // A frame start drops any partial frame and keeps only slot 0
        if (ld) buf_nxt = {{(FRAME_BITS-1){1'b0}}, bus.D};
    end
    always_ff @(posedge CK or negedge RN)
        if (!RN) begin
            buf_q <= '0;
            bus.C <= '0;
            bus.VALID <= 1'b0;
            bus.OVR <= 1'b0;
            bus.SYNCERR <= 1'b0;
        end else begin
            if (ld || en) buf_q <= buf_nxt;
            if (wrap) bus.C <= buf_nxt;
            bus.VALID <= wrap || (bus.VALID && !bus.ACK);
            bus.OVR <= wrap && bus.VALID && !bus.ACK;
            bus.SYNCERR <= serr;
        end
endmodule

// File: tb/tb_s420_deser.sv
// tb_s420_deser: random and directed stimulus checked against a frame-queue reference model.
module tb_s420_deser;
    import s420_pkg::*;
    logic ck = 1'b0, rn = 1'b0;
    int n_chk = 0, n_err = 0;
    s420_deser_if bus ();
    s420_deser dut (.CK(ck), .RN(rn), .bus(bus));
    always #5 ck = ~ck;
    bit m_q[$];
    bit m_in;
    logic [FRAME_BITS-1:0] m_c;
    bit m_valid, m_ovr, m_serr;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic chk_all();
        chk("c", 32'(bus.C), 32'(m_c));
        chk("valid", 32'(bus.VALID), 32'(m_valid));
        chk("ovr", 32'(bus.OVR), 32'(m_ovr));
        chk("syncerr", 32'(bus.SYNCERR), 32'(m_serr));
        chk("idx", 32'(bus.IDX), m_q.size());
    endtask
    task automatic model_clear();
        m_q.delete();
        m_in = 0;
        m_c = '0;
        m_valid = 0;
        m_ovr = 0;
        m_serr = 0;
    endtask
    // Frame = queue of received bits; its length is the next slot
    task automatic model_edge(input bit p, input bit s, input bit d, input bit a);
        bit done = 0;
        m_ovr = 0;
        m_serr = 0;
        if (p && s) begin
            m_serr = m_in && m_q.size() != 0;
            m_q.delete();
            m_q.push_back(d);
            m_in = 1;
        end else if (p && m_in) begin
            m_q.push_back(d);
            if (m_q.size() == SLOT_COUNT) begin
                done = 1;
                m_ovr = m_valid && !a;
                for (int i = 0; i < SLOT_COUNT; i++) m_c[i] = m_q[i];
                m_q.delete();
            end
        end
        m_valid = done || (m_valid && !a);
    endtask
    task automatic step(input bit p, input bit s, input bit d, input bit a);
        bus.P_0 = p;
        bus.SYNC = s;
        bus.D = d;
        bus.ACK = a;
        @(posedge ck);
        model_edge(p, s, d, a);
        @(negedge ck);
        chk_all();
    endtask
    task automatic send(input logic [FRAME_BITS-1:0] w, input bit sync, input int gap, input bit ack_last);
        for (int i = 0; i < FRAME_BITS; i++) begin
            step(1, sync && i == 0, w[i], ack_last && i == FRAME_BITS - 1);
            if (i == 4 || i == 11)
                for (int g = 0; g < gap; g++) step(0, 1'($urandom), 1'($urandom), 0);
        end
    endtask
    task automatic do_reset();
        rn = 1'b0;
        model_clear();
        #1;
        chk_all();
        chk("rst_c", 32'(bus.C), 0);
        @(negedge ck);
        rn = 1'b1;
    endtask
    initial begin
        bus.P_0 = 0; bus.SYNC = 0; bus.D = 0; bus.ACK = 0;
        do_reset();
        send(17'h1A5C3, 1, 0, 0);
        chk("happy_c", 32'(bus.C), 32'h1A5C3);
        chk("happy_valid", 32'(bus.VALID), 1);
        step(0, 0, 0, 1);
        chk("ack_valid", 32'(bus.VALID), 0);
        send(17'h1A5C3, 1, 3, 0);
        chk("gap_c", 32'(bus.C), 32'h1A5C3);
        step(0, 0, 0, 1);
        send(17'h00001, 1, 0, 0);
        send(17'h1FFFE, 0, 0, 0);
        chk("ovr_pulse", 32'(bus.OVR), 1);
        chk("ovr_c", 32'(bus.C), 32'h1FFFE);
        step(0, 0, 0, 0);
        chk("ovr_once", 32'(bus.OVR), 0);
        send(17'h0F0F0, 0, 0, 1);
        chk("coinc_valid", 32'(bus.VALID), 1);
        chk("coinc_ovr", 32'(bus.OVR), 0);
        chk("coinc_c", 32'(bus.C), 32'h0F0F0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(1, i == 0, 1, 0);
        chk("pre_resync_idx", 32'(bus.IDX), 7);
        step(1, 1, 0, 0);
        chk("resync_err", 32'(bus.SYNCERR), 1);
        chk("resync_idx", 32'(bus.IDX), 1);
        for (int i = 1; i < FRAME_BITS; i++) step(1, 0, 0, 0);
        chk("resync_c", 32'(bus.C), 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, i == 0, 1, 0);
        chk("pre_rst_idx", 32'(bus.IDX), 9);
        do_reset();
        chk("rst_valid", 32'(bus.VALID), 0);
        step(1, 0, 1, 0);
        chk("idle_idx", 32'(bus.IDX), 0);
        send(17'h15555, 1, 0, 0);
        chk("post_rst_c", 32'(bus.C), 32'h15555);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(3) != 0, $urandom_range(19) == 0, 1'($urandom), $urandom_range(9) < 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/s420_deser.md
Name: s420_deser

Overview:
- Receive-side counterpart of the s420 serial select/compare path: slot-indexed serial bits in, 17-bit parallel word out.
- Takes one serial bit per enabled cycle and writes it into the slot given by a free-running slot counter.
- Delivers each completed frame on a registered parallel bus with a valid/ack handshake.
- Sits between the serial link and the parallel C_0..C_16 consumer in the ISCAS-flavoured test harness.

Parameters:
- FRAME_BITS, 17, number of slots per frame (slot 0 = P_0 slot, slots 1..16 = counter-decoded slots).
- IDX_W, 5, slot index width; must satisfy 2**IDX_W >= FRAME_BITS.

Ports:
- CK       in   1           rising-edge clock.
- RN       in   1           reset, asynchronous, active-low.
- P_0      in   1           bit enable; D is sampled only in cycles where P_0=1.
- SYNC     in   1           frame-start marker; qualified by P_0.
- D        in   1           serial data bit.
- ACK      in   1           consumer acknowledge of the current word.
- C        out  FRAME_BITS  last completed frame; slot i maps to bit i.
- VALID    out  1           C holds an unacknowledged frame.
- OVR      out  1           one-cycle pulse: an unacknowledged frame was overwritten.
- SYNCERR  out  1           one-cycle pulse: SYNC arrived mid-frame.
- IDX      out  IDX_W       next slot to be written.

Behaviour:
- Reset (RN=0, asynchronous):
  - state=IDLE, IDX=0, shift buffer=0, C=0.
  - VALID=0, OVR=0, SYNCERR=0.
- All outputs are registered.
- State IDLE:
  - P_0&SYNC: D -> buffer slot 0, IDX<=1, go to COLLECT.
  - P_0 without SYNC: ignored; IDX stays 0 and buffer is unchanged.
- State COLLECT, on a cycle with P_0=1:
  - D is written to buffer[IDX].
  - If IDX==FRAME_BITS-1: frame completes. C <= buffer with this bit merged, VALID<=1, IDX<=0, stay in COLLECT. Back-to-back frames need no new SYNC.
  - Otherwise: IDX<=IDX+1.
- P_0=0 cycles: nothing changes, whatever SYNC and D are; gaps in P_0 are legal anywhere in a frame.
- SYNC&P_0 in COLLECT:
  - IDX==0: normal frame start, no error.
  - IDX!=0: discard the partial frame (clear the buffer), D -> slot 0, IDX<=1, SYNCERR pulses for 1 cycle.
  - SYNC never causes completion; it always writes slot 0.
- Latency: C and VALID update on the clock edge that samples the last slot, so they are visible in the following cycle.
- Handshake:
  - VALID&ACK clears VALID at the next edge.
  - ACK while VALID=0 is ignored.
  - C holds its value until the next completion.
- Simultaneous completion and ACK: VALID stays 1, C takes the new word, no OVR.
- Completion while VALID=1 and ACK=0: C is overwritten, VALID stays 1, OVR pulses 1 cycle.
- The index counter never exceeds FRAME_BITS-1; it wraps FRAME_BITS-1 -> 0.
- Reset mid-frame: the partial frame is lost and the block returns to IDLE, so the next frame requires SYNC.

Decomposition:
- Shared package s420_pkg:
  - FRAME_BITS default.
  - State typedef {IDLE, COLLECT}.
  - Slot-count constant 17, shared with the transmitter-side bench model.
- One sub-module, s420_slot_ctr: mod-FRAME_BITS up-counter with enable, synchronous load-to-1 (resync) and wrap flag. It is built as cascaded 4-bit nibble stages with carry enable, in the same style as the s420 counter.

Test Plan:
- Happy path: reset, then SYNC+P_0 on the first bit, then 17 bits LSB-first of 17'h1A5C3 with P_0 held high -> VALID=1 the cycle after the 17th bit, C=17'h1A5C3, IDX=0. ACK next cycle -> VALID=0.
- Gaps: same frame with P_0 low for 3 cycles after slots 4 and 11 -> identical C=17'h1A5C3. IDX holds its value during the gaps.
- Overrun: two back-to-back frames 17'h00001 then 17'h1FFFE with no ACK -> OVR pulses exactly once at the second completion, C=17'h1FFFE, VALID=1.
- ACK coincident with completion of the second frame -> VALID stays 1, C is the new word, OVR=0.
- Resync: SYNC+P_0 while IDX=7 -> SYNCERR pulses 1 cycle, IDX=1, bits 1..6 of the old frame do not appear in the next C.
- Reset mid-frame: RN low at IDX=9 -> all outputs 0 immediately. Afterwards P_0 without SYNC leaves IDX=0; a following SYNC frame completes correctly.
